// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: pipeline stall/flush/hold sequencing for the PC, IF/ID and
// ID/EX buffers. It detects load-use hazards and runs multi-cycle branch
// flushes and multi-cycle EX operations through a small FSM. It also keeps
// saturating stall and flush performance counters.
//
// Handshake note: there is no valid/ready traffic in this block. All control
// outputs are combinational from the current state, the down-counter and this
// cycle's inputs. The consumers sample them on the same rising edge.
module hazard_flush_ctrl #(
    parameter int BR_PENALTY = 1,   // flush cycles per taken branch, 1..4
    parameter int MC_CYCLES  = 4,   // total EX occupancy of a multi-cycle op, 1..15
    parameter int CNT_W      = 16   // performance counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ifid_rs,
    input  logic [3:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [3:0]       idex_rt,
    input  logic             idex_memread,
    input  logic             ex_br_taken,
    input  logic             ex_mc_start,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_hold,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MC_BUSY  = 2'd2
    } state_t;

    // The remaining cycles after the first one are loaded into the down-counter.
    localparam logic [3:0]       BR_LOAD = 4'(BR_PENALTY - 1);
    localparam logic [3:0]       MC_LOAD = 4'(MC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic       w_lu_haz;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Load-use hazard: the load in ID/EX writes a register that the IF/ID instruction reads. Register 0 never causes a hazard.
    always_comb begin
        w_lu_haz = idex_memread && (idex_rt != 4'd0) &&
                   ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    end

    // State and down-counter registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic and decoded pipeline controls (priority: branch > multi-cycle > load-use).
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_hold    = 1'b0;
        case (r_state)
            RUN: begin
                if (ex_br_taken) begin
                    // The PC still loads the branch target in this cycle.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BR_PENALTY > 1) begin
                        w_next_cnt   = BR_LOAD;
                        w_next_state = BR_FLUSH;
                    end
                end else if (ex_mc_start) begin
                    // A single-cycle op needs no stall. It still masks a load-use bubble in this cycle.
                    if (MC_CYCLES > 1) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_hold    = 1'b1;
                        w_next_cnt   = MC_LOAD;
                        w_next_state = MC_BUSY;
                    end
                end else if (w_lu_haz) begin
                    // One bubble; the load has moved on by the next cycle.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            BR_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            end
            MC_BUSY: begin
                // Inputs are ignored here so the held op cannot retrigger itself.
                if (r_cnt > 4'd1) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_hold  = 1'b1;
                    w_next_cnt = r_cnt - 4'd1;
                end else begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            end
            default: begin
                w_next_state = RUN;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Saturating performance counters; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (ifid_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign state_o   = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
